// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: instruction field layout and fetch FSM encoding shared by fetch and decode.
package instr_fetch_unit_pkg;
    localparam int PART_W  = 5;
    localparam int NPARTS  = 5;
    localparam int INSTR_W = PART_W * NPARTS;
    localparam int PART1_HI = 24;
    localparam int PART1_LO = 20;
    localparam int PART2_HI = 19;
    localparam int PART2_LO = 15;
    localparam int PART3_HI = 14;
    localparam int PART3_LO = 10;
    localparam int PART4_HI = 9;
    localparam int PART4_LO = 5;
    localparam int PART5_HI = 4;
    localparam int PART5_LO = 0;
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/instr_fetch_unit_field_split.sv
// instr_field_split: splits one instruction word into its five fields, part1 being the opcode.
module instr_field_split
    import instr_fetch_unit_pkg::*;
(
    input  logic [INSTR_W-1:0] word,
    output logic [PART_W-1:0]  part1,
    output logic [PART_W-1:0]  part2,
    output logic [PART_W-1:0]  part3,
    output logic [PART_W-1:0]  part4,
    output logic [PART_W-1:0]  part5
);
    assign part1 = word[PART1_HI:PART1_LO];
    assign part2 = word[PART2_HI:PART2_LO];
    assign part3 = word[PART3_HI:PART3_LO];
    assign part4 = word[PART4_HI:PART4_LO];
    assign part5 = word[PART5_HI:PART5_LO];
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches instruction words, splits them into fields and presents them to decode
// through a valid/ready output register, with PC redirects that discard stale responses.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
)
(
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [PART_W-1:0]  part1_out,
    output logic [PART_W-1:0]  part2_out,
    output logic [PART_W-1:0]  part3_out,
    output logic [PART_W-1:0]  part4_out,
    output logic [PART_W-1:0]  part5_out,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc
);
    fetch_state_t state, state_next;
    logic [PC_W-1:0] pc;
    logic slot_free, load;
    logic [PART_W-1:0] p1, p2, p3, p4, p5;

    assign slot_free = !instr_valid || instr_ready;
    assign imem_addr = pc;

    instr_field_split u_split (
        .word  (imem_rdata),
        .part1 (p1),
        .part2 (p2),
        .part3 (p3),
        .part4 (p4),
        .part5 (p5)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    // A redirect while a response is owed must still swallow that response, hence S_DRAIN.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        load       = 1'b0;
        case (state)
            S_FETCH: begin
                if (!redirect && slot_free) begin
                    imem_req   = !rst;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_valid) begin
                    load       = !redirect;
                    state_next = S_FETCH;
                end else if (redirect) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN:  state_next = imem_valid ? S_FETCH : S_DRAIN;
            default:  state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            instr_pc    <= '0;
            part1_out   <= '0;
            part2_out   <= '0;
            part3_out   <= '0;
            part4_out   <= '0;
            part5_out   <= '0;
        end else begin
            pc          <= redirect ? redirect_pc : load ? pc + PC_W'(1) : pc;
            instr_valid <= redirect ? 1'b0 : load ? 1'b1 : instr_valid && !instr_ready;
            if (load) begin
                instr_pc  <= pc;
                part1_out <= p1;
                part2_out <= p2;
                part3_out <= p3;
                part4_out <= p4;
                part5_out <= p5;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed stimulus against a pipelined memory model; expected words are
// queued as fetches are provoked and a monitor compares them on every decode transfer.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [24:0] imem_rdata;
    logic        imem_valid;
    logic [4:0]  part1_out, part2_out, part3_out, part4_out, part5_out;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [24:0] fields;
    logic [41:0] held;

    typedef struct packed {logic [15:0] pc; logic [24:0] word;} sb_t;
    typedef struct {logic [15:0] a; int due;} mreq_t;
    sb_t   sb[$];
    sb_t   mon_e;
    mreq_t mq[$];
    mreq_t mr;
    int    mc;
    int    lat;
    int    passed = 0;
    int    total  = 0;

    always #5 clk = ~clk;
    assign fields = {part1_out, part2_out, part3_out, part4_out, part5_out};

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .part1_out   (part1_out),
        .part2_out   (part2_out),
        .part3_out   (part3_out),
        .part4_out   (part4_out),
        .part5_out   (part5_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    function automatic logic [24:0] mem_word(input logic [15:0] a);
        return 25'h1A2B3C4 ^ 25'({16'h0, a} * 32'h0012345);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < 20);
        check(name, {63'h0, instr_valid}, 64'h1);
    endtask

    // Memory keeps answering requests even across reset, so stale responses really occur.
    initial begin
        imem_valid = 1'b0;
        imem_rdata = '0;
        mc = 0;
        forever begin
            @(posedge clk);
            #1;
            mc++;
            imem_valid = 1'b0;
            if (mq.size() > 0 && mq[0].due == mc) begin
                imem_valid = 1'b1;
                imem_rdata = mem_word(mq[0].a);
                mq.delete(0);
            end
            @(negedge clk);
            if (imem_req) begin
                mr.a   = imem_addr;
                mr.due = mc + lat;
                mq.push_back(mr);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL sb_unexpected: transfer of pc 0x%0h, expected no transfer", instr_pc);
            end else begin
                mon_e = sb.pop_front();
                check("sb_pc", {48'h0, instr_pc}, {48'h0, mon_e.pc});
                check("sb_fields", {39'h0, fields}, {39'h0, mon_e.word});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; lat = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", {63'h0, imem_req}, 64'h0);
        check("rst_addr", {48'h0, imem_addr}, 64'h0);
        check("rst_valid", {63'h0, instr_valid}, 64'h0);
        check("rst_pc", {48'h0, instr_pc}, 64'h0);
        check("rst_fields", {39'h0, fields}, 64'h0);
        // first fetch after reset, 1-cycle memory
        drv(); rst = 1'b0; sb.push_back({16'h0000, 25'h1A2B3C4});
        @(negedge clk);
        check("t1_req", {47'h0, imem_req, imem_addr}, {47'h0, 1'b1, 16'h0000});
        drv(); @(negedge clk);
        check("t1_valid_c2", {63'h0, instr_valid}, 64'h0);
        drv(); @(negedge clk);
        check("t1_valid_c3", {63'h0, instr_valid}, 64'h1);
        check("t1_fields", {39'h0, fields}, {39'h0, 5'h1A, 5'h05, 5'h0C, 5'h1E, 5'h04});
        check("t1_pc", {48'h0, instr_pc}, 64'h0);
        held = {instr_valid, instr_pc, fields};
        for (int i = 0; i < 5; i++) begin
            drv(); @(negedge clk);
            check("t2_hold", {22'h0, instr_valid, instr_pc, fields}, {22'h0, held});
            check("t2_noreq", {63'h0, imem_req}, 64'h0);
        end
        drv(); instr_ready = 1'b1; sb.push_back({16'h0001, mem_word(16'h0001)});
        @(negedge clk);
        check("t2_req", {47'h0, imem_req, imem_addr}, {47'h0, 1'b1, 16'h0001});
        drv(); instr_ready = 1'b0;
        wait_valid("t2_valid");
        // redirect while waiting on a 3-cycle memory
        lat = 3;
        drv(); instr_ready = 1'b1;
        @(negedge clk);
        check("t3_req0", {47'h0, imem_req, imem_addr}, {47'h0, 1'b1, 16'h0002});
        drv(); instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h0040;
        drv(); redirect = 1'b0;
        begin
            int n = 0;
            @(negedge clk);
            while (!imem_req && n < 10) begin
                check("t3_flushed", {63'h0, instr_valid}, 64'h0);
                @(negedge clk);
                n++;
            end
        end
        check("t3_req", {47'h0, imem_req, imem_addr}, {47'h0, 1'b1, 16'h0040});
        sb.push_back({16'h0040, mem_word(16'h0040)});
        wait_valid("t3_valid");
        // redirect coinciding with the response
        drv(); instr_ready = 1'b1;
        @(negedge clk);
        check("t4_req0", {47'h0, imem_req, imem_addr}, {47'h0, 1'b1, 16'h0041});
        drv(); instr_ready = 1'b0;
        drv();
        drv(); redirect = 1'b1; redirect_pc = 16'h0080; lat = 1;
        drv(); redirect = 1'b0;
        @(negedge clk);
        check("t4_req", {47'h0, imem_req, imem_addr}, {47'h0, 1'b1, 16'h0080});
        check("t4_novalid", {63'h0, instr_valid}, 64'h0);
        wait_valid("t4_valid");
        check("t4_pc", {48'h0, instr_pc}, 64'h0080);
        check("t4_fields", {39'h0, fields}, {39'h0, mem_word(16'h0080)});
        // flush presented word, fetch top of address space and wrap
        drv(); redirect = 1'b1; redirect_pc = 16'hFFFF;
        @(negedge clk);
        check("t5_still_valid", {63'h0, instr_valid}, 64'h1);
        check("t5_noreq", {63'h0, imem_req}, 64'h0);
        drv(); redirect = 1'b0;
        @(negedge clk);
        check("t5_flushed", {63'h0, instr_valid}, 64'h0);
        check("t5_req", {47'h0, imem_req, imem_addr}, {47'h0, 1'b1, 16'hFFFF});
        sb.push_back({16'hFFFF, mem_word(16'hFFFF)});
        wait_valid("t5_valid");
        drv(); instr_ready = 1'b1; sb.push_back({16'h0000, mem_word(16'h0000)});
        @(negedge clk);
        check("t5_wrap", {47'h0, imem_req, imem_addr}, {47'h0, 1'b1, 16'h0000});
        drv(); instr_ready = 1'b0;
        wait_valid("t5_valid2");
        // reset mid-transaction; the late response lands in the first post-reset cycle
        lat = 3;
        drv(); instr_ready = 1'b1;
        @(negedge clk);
        check("t6_req0", {47'h0, imem_req, imem_addr}, {47'h0, 1'b1, 16'h0001});
        drv(); instr_ready = 1'b0; rst = 1'b1; lat = 2;
        drv();
        @(negedge clk);
        check("t6_rst_req", {63'h0, imem_req}, 64'h0);
        check("t6_rst_valid", {63'h0, instr_valid}, 64'h0);
        drv(); rst = 1'b0; sb.push_back({16'h0000, mem_word(16'h0000)});
        @(negedge clk);
        check("t6_req", {47'h0, imem_req, imem_addr}, {47'h0, 1'b1, 16'h0000});
        check("t6_c1_valid", {63'h0, instr_valid}, 64'h0);
        drv(); @(negedge clk);
        check("t6_stale_ignored", {63'h0, instr_valid}, 64'h0);
        wait_valid("t6_valid");
        drv(); instr_ready = 1'b1;
        drv(); instr_ready = 1'b0;
        repeat (3) @(posedge clk);
        check("sb_drained", 64'(sb.size()), 64'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
